// File: rtl/sel_sequencer_if.sv
// Select-index bus between the sequencer and its downstream consumer.
// The sequencer (master) offers an index with sel_valid; the consumer (slave)
// accepts it with sel_ack. Sweep markers travel alongside the index.
interface sel_sequencer_if #(
  parameter int SEL_W = 6
);
  logic [SEL_W-1:0] sel;
  logic             sel_valid;
  logic             sel_ack;
  logic             frame_toggle;
  logic             wrap_pulse;

  modport master (
    output sel,
    output sel_valid,
    output frame_toggle,
    output wrap_pulse,
    input  sel_ack
  );

  modport slave (
    input  sel,
    input  sel_valid,
    input  frame_toggle,
    input  wrap_pulse,
    output sel_ack
  );
endinterface

// File: rtl/sel_sequencer.sv
// Programmable select sequencer: sweeps an index 0..last, offering each value
// with a valid/ack handshake and holding it for a configured dwell after ack.
// Configuration is captured into shadow registers when a sweep starts, so the
// control inputs may change freely while a sweep is running.
module sel_sequencer #(
  parameter int SEL_W   = 6,
  parameter int DWELL_W = 8
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_start,
  input  logic               i_stop,
  input  logic               i_pause,
  input  logic [DWELL_W-1:0] i_cfg_dwell,
  input  logic [SEL_W-1:0]   i_cfg_last,
  input  logic               i_cfg_oneshot,
  output logic               o_busy,
  sel_sequencer_if.master    sel_if
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PRESENT = 2'd1,
    S_DWELL   = 2'd2,
    S_ADVANCE = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [SEL_W-1:0]   r_sel;
  logic [SEL_W-1:0]   w_sel_next;
  logic               r_valid;
  logic               w_valid_next;
  logic               r_toggle;
  logic               w_toggle_next;
  logic               r_wrap;
  logic               w_wrap_next;
  logic               r_busy;
  logic               w_busy_next;
  logic [DWELL_W-1:0] r_cnt;
  logic [DWELL_W-1:0] w_cnt_next;
  logic [DWELL_W-1:0] r_sh_dwell;
  logic [DWELL_W-1:0] w_sh_dwell_next;
  logic [SEL_W-1:0]   r_sh_last;
  logic [SEL_W-1:0]   w_sh_last_next;
  logic               r_sh_oneshot;
  logic               w_sh_oneshot_next;

  // Dwell ends on the cycle the counter reaches dwell-1; only evaluated in
  // DWELL, which is never entered with a zero dwell, so no underflow matters.
  logic [DWELL_W-1:0] w_dwell_last;
  logic               w_at_last;
  assign w_dwell_last = r_sh_dwell - {{(DWELL_W-1){1'b0}}, 1'b1};
  assign w_at_last    = (r_sel == r_sh_last);

  // State and output registers; every output comes straight from a flop.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state      <= S_IDLE;
      r_sel        <= '0;
      r_valid      <= 1'b0;
      r_toggle     <= 1'b0;
      r_wrap       <= 1'b0;
      r_busy       <= 1'b0;
      r_cnt        <= '0;
      r_sh_dwell   <= '0;
      r_sh_last    <= '0;
      r_sh_oneshot <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_sel        <= w_sel_next;
      r_valid      <= w_valid_next;
      r_toggle     <= w_toggle_next;
      r_wrap       <= w_wrap_next;
      r_busy       <= w_busy_next;
      r_cnt        <= w_cnt_next;
      r_sh_dwell   <= w_sh_dwell_next;
      r_sh_last    <= w_sh_last_next;
      r_sh_oneshot <= w_sh_oneshot_next;
    end
  end

  // Next-state and next-output logic; stop overrides whatever the FSM chose.
  always_comb begin
    w_state_next      = r_state;
    w_sel_next        = r_sel;
    w_valid_next      = r_valid;
    w_toggle_next     = r_toggle;
    w_wrap_next       = 1'b0;
    w_busy_next       = r_busy;
    w_cnt_next        = r_cnt;
    w_sh_dwell_next   = r_sh_dwell;
    w_sh_last_next    = r_sh_last;
    w_sh_oneshot_next = r_sh_oneshot;

    case (r_state)
      S_IDLE: begin
        if (i_start && !i_stop) begin
          w_sh_dwell_next   = i_cfg_dwell;
          w_sh_last_next    = i_cfg_last;
          w_sh_oneshot_next = i_cfg_oneshot;
          w_sel_next        = '0;
          w_valid_next      = 1'b1;
          w_busy_next       = 1'b1;
          w_state_next      = S_PRESENT;
        end
      end

      S_PRESENT: begin
        if (sel_if.sel_ack) begin
          w_valid_next = 1'b0;
          w_cnt_next   = '0;
          w_state_next = (r_sh_dwell != '0) ? S_DWELL : S_ADVANCE;
        end
      end

      S_DWELL: begin
        if (!i_pause) begin
          w_cnt_next = r_cnt + {{(DWELL_W-1){1'b0}}, 1'b1};
          if (r_cnt == w_dwell_last) begin
            w_state_next = S_ADVANCE;
          end
        end
      end

      S_ADVANCE: begin
        if (w_at_last) begin
          w_sel_next    = '0;
          w_toggle_next = ~r_toggle;
          w_wrap_next   = 1'b1;
          if (r_sh_oneshot) begin
            w_busy_next  = 1'b0;
            w_state_next = S_IDLE;
          end else begin
            w_valid_next = 1'b1;
            w_state_next = S_PRESENT;
          end
        end else begin
          w_sel_next   = r_sel + {{(SEL_W-1){1'b0}}, 1'b1};
          w_valid_next = 1'b1;
          w_state_next = S_PRESENT;
        end
      end

      default: begin
        w_state_next = S_IDLE;
      end
    endcase

    if (i_stop && (r_state != S_IDLE)) begin
      w_state_next  = S_IDLE;
      w_valid_next  = 1'b0;
      w_busy_next   = 1'b0;
      w_wrap_next   = 1'b0;
      w_sel_next    = r_sel;
      w_toggle_next = r_toggle;
    end
  end

  assign sel_if.sel          = r_sel;
  assign sel_if.sel_valid    = r_valid;
  assign sel_if.frame_toggle = r_toggle;
  assign sel_if.wrap_pulse   = r_wrap;
  assign o_busy              = r_busy;

endmodule

// File: doc/sel_sequencer.md
# sel_sequencer

Programmable select sequencer that steps a SEL_W-bit select index from 0 to a configured last value and then wraps, dwelling a configured number of cycles per index. Each new index is offered to the downstream consumer (mux/pattern datapath) with a valid/ack handshake, and dwell counting starts only after acknowledgement. A frame toggle and wrap pulse mark each completed sweep. Start, stop, pause and one-shot controls let the top level or test logic schedule sweeps instead of free-running.

## Interface
- SEL_W, 6, width of select index and cfg_last
- DWELL_W, 8, width of dwell counter and cfg_dwell
- clk  in  1  single clock; all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- start  in  1  begin a sweep when idle (level sampled each edge)
- stop  in  1  abort sweep; wins over start
- pause  in  1  freeze dwell counter while high
- cfg_dwell  in  DWELL_W  cycles to hold each index after ack
- cfg_last  in  SEL_W  last index before wrap
- cfg_oneshot  in  1  1: return to idle after one sweep
- sel_ack  in  1  consumer accepts current sel
- sel  out  SEL_W  current select index
- sel_valid  out  1  sel is new and awaiting ack
- frame_toggle  out  1  flips on every wrap
- wrap_pulse  out  1  one-cycle pulse on wrap
- busy  out  1  sweep in progress

## Operation
- Reset (rst_n=0 at edge): state IDLE; sel=0, sel_valid=0, frame_toggle=0, wrap_pulse=0, busy=0, dwell counter=0, shadow config=0.
- States: IDLE, PRESENT, DWELL, ADVANCE.
- IDLE: start=1 and stop=0 -> latch cfg_dwell, cfg_last, cfg_oneshot into shadow registers, sel<=0, sel_valid<=1, busy<=1, go PRESENT. start while not IDLE ignored.
- PRESENT: sel_valid=1 held until sel_ack=1 sampled; then sel_valid<=0, counter<=0, go DWELL if shadow dwell != 0, else go ADVANCE.
- DWELL: counter increments each edge with pause=0, holds with pause=1; when counter == dwell-1 and pause=0, go ADVANCE.
- ADVANCE (one cycle): if sel == shadow last: sel<=0, frame_toggle flips, wrap_pulse<=1; then go IDLE with busy<=0 if shadow oneshot, else PRESENT with sel_valid<=1. Else sel<=sel+1, sel_valid<=1, go PRESENT.
- stop=1 in any non-IDLE state: next state IDLE, sel_valid<=0, busy<=0, wrap_pulse<=0; sel holds its value; frame_toggle unchanged. stop in IDLE: no effect.
- Config inputs ignored after latching; changes take effect at next start.
- cfg_last=0: every ADVANCE is a wrap (sel stays 0, toggle flips each pass).
- sel_ack outside PRESENT is ignored. pause has no effect outside DWELL.
- Arithmetic: sel+1 never overflows since sel <= shadow last <= 2^SEL_W-1; counter compare uses DWELL_W bits, no wrap.

## Timing
- All outputs registered; wrap_pulse high exactly one cycle, coincident with sel returning to 0.
- start sampled at edge N -> sel_valid=1, busy=1, sel=0 after edge N.
- sel_ack sampled at edge M -> sel_valid=0 after M; next index with sel_valid=1 after edge M+D+1 (D = shadow dwell, no pause); D=0 gives M+1.
- With sel_ack tied high: each index valid 1 cycle, full index period D+2 cycles; sweep period (last+1)*(D+2).
- Each pause cycle in DWELL extends the period by one cycle.
- Oneshot: busy falls after the wrap ADVANCE edge, same edge wrap_pulse rises.
- start and stop same edge in IDLE: stays IDLE.

## Test plan
- Reset mid-sweep (sel=5, DWELL): rst_n=0 one edge -> all outputs 0, IDLE; start required to resume.
- cfg_dwell=100, cfg_last=37, oneshot=0, sel_ack=1, start pulse -> sel 0..37 then 0, each index period 102 cycles, wrap_pulse every 3876 cycles, frame_toggle flips each wrap.
- cfg_dwell=3, cfg_last=2, sel_ack held low 10 cycles after each sel_valid -> sel_valid stays high 10 cycles, no advance until ack, then 4 cycles to next sel_valid.
- cfg_dwell=0, cfg_last=0, oneshot=1, ack=1 -> sel stays 0, single wrap_pulse, busy high 2 cycles, returns IDLE.
- cfg_dwell=5, pause high 3 cycles in DWELL -> index period 10 cycles instead of 7; pause during PRESENT no effect.
- stop asserted at sel=4 in DWELL, with start same edge -> IDLE next cycle, sel=4 held, busy=0, sel_valid=0; later start restarts at sel=0 with newly latched config.
